// File: rtl/ball_pkg.sv
// Shared constants and types for the ball sprite renderer.
//   RADIUS_DEF  default ball radius in pixels
//   HIDE_X_DEF  X value that marks the ball as pocketed/hidden
//   POS_X_* / POS_Y_*  field slices of the 20-bit PIO position word {x, y}
//   state_t     frame-sync FSM encoding
package ball_pkg;

    localparam int         RADIUS_DEF = 4;
    localparam logic [9:0] HIDE_X_DEF = 10'h3FF;

    localparam int POS_X_MSB = 19;
    localparam int POS_X_LSB = 10;
    localparam int POS_Y_MSB = 9;
    localparam int POS_Y_LSB = 0;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        ACTIVE    = 1'b1
    } state_t;

endpackage

// File: rtl/circle_hit_pipe.sv
// Two-stage filled-circle hit test. The top instantiates one per ball.
// Ports:
//   clk, i_rst_n        clock, async active-low reset
//   i_valid             pixel coordinate valid
//   i_hide              suppress any hit for this pixel
//   i_x, i_y            pixel coordinate (unsigned)
//   i_cx, i_cy          circle centre (unsigned)
//   o_hit               pixel inside circle, qualified by o_valid
//   o_valid             i_valid delayed by two cycles
module circle_hit_pipe #(
    parameter int RADIUS = 4
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic       i_hide,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic [9:0] i_cx,
    input  logic [9:0] i_cy,
    output logic       o_hit,
    output logic       o_valid
);

    localparam logic [21:0] R_SQ = 22'(RADIUS * RADIUS);

    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy;
    logic signed [10:0] r_dx;
    logic signed [10:0] r_dy;
    logic               r_valid1;
    logic               r_hide1;

    logic signed [21:0] w_dx_ext;
    logic signed [21:0] w_dy_ext;
    logic signed [21:0] w_dx_sq;
    logic signed [21:0] w_dy_sq;
    logic        [21:0] w_sum;

    // Zero-extend before subtracting so the difference is a true signed
    // offset; no wrap-around near the screen edges.
    assign w_dx = {1'b0, i_x} - {1'b0, i_cx};
    assign w_dy = {1'b0, i_y} - {1'b0, i_cy};

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dx     <= '0;
            r_dy     <= '0;
            r_valid1 <= 1'b0;
            r_hide1  <= 1'b1;
        end else begin
            r_dx     <= w_dx;
            r_dy     <= w_dy;
            r_valid1 <= i_valid;
            r_hide1  <= i_hide;
        end
    end

    // Squares are non-negative and at most 1023^2, so the 22-bit sum cannot overflow.
    assign w_dx_ext = 22'(r_dx);
    assign w_dy_ext = 22'(r_dy);
    assign w_dx_sq  = w_dx_ext * w_dx_ext;
    assign w_dy_sq  = w_dy_ext * w_dy_ext;
    assign w_sum    = unsigned'(w_dx_sq) + unsigned'(w_dy_sq);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hit   <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            o_hit   <= r_valid1 & ~r_hide1 & (w_sum <= R_SQ);
            o_valid <= r_valid1;
        end
    end

endmodule

// File: rtl/ball_sprite_render.sv
// Ball sprite renderer: latches the PIO ball position once per frame and
// flags pixels that fall inside the ball (2-cycle pipelined).
// Ports:
//   clk, reset_n    clock, async active-low reset
//   ball_pos_in     {x[9:0], y[9:0]} from the PIO, may change any cycle
//   frame_sync      one-cycle pulse at start of vertical blanking
//   pix_valid       draw_x/draw_y valid
//   draw_x, draw_y  current pixel coordinate
//   is_ball         pixel inside ball, qualified by is_ball_valid
//   is_ball_valid   pix_valid delayed by two cycles
//   pos_updated     one-cycle pulse after a frame_sync that changed the position
//
// state     | meaning
// WAIT_SYNC | no trusted position yet; every pixel is drawn as not-ball
// ACTIVE    | shadow position valid; reloaded on each frame_sync
module ball_sprite_render
    import ball_pkg::*;
#(
    parameter int         RADIUS = RADIUS_DEF,
    parameter logic [9:0] HIDE_X = HIDE_X_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [19:0] ball_pos_in,
    input  logic        frame_sync,
    input  logic        pix_valid,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    output logic        is_ball,
    output logic        is_ball_valid,
    output logic        pos_updated
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [19:0] r_shadow;
    logic [19:0] w_shadow_nxt;
    logic        w_upd_nxt;
    logic        w_hide;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= WAIT_SYNC;
            r_shadow    <= '0;
            pos_updated <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shadow    <= w_shadow_nxt;
            pos_updated <= w_upd_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_upd_nxt    = 1'b0;
        case (r_state)
            WAIT_SYNC: begin
                if (frame_sync) begin
                    w_state_nxt  = ACTIVE;
                    w_shadow_nxt = ball_pos_in;
                    // First load always counts as an update, even if it matches the reset value.
                    w_upd_nxt    = 1'b1;
                end
            end
            ACTIVE: begin
                if (frame_sync) begin
                    w_shadow_nxt = ball_pos_in;
                    w_upd_nxt    = (ball_pos_in != r_shadow);
                end
            end
            default: w_state_nxt = WAIT_SYNC;
        endcase
    end

    // Uses the registered shadow, so a pixel coincident with frame_sync
    // is still judged against the previous frame's position.
    assign w_hide = (r_shadow[POS_X_MSB:POS_X_LSB] == HIDE_X) | (r_state == WAIT_SYNC);

    circle_hit_pipe #(
        .RADIUS (RADIUS)
    ) u_hit_pipe (
        .clk     (clk),
        .i_rst_n (reset_n),
        .i_valid (pix_valid),
        .i_hide  (w_hide),
        .i_x     (draw_x),
        .i_y     (draw_y),
        .i_cx    (r_shadow[POS_X_MSB:POS_X_LSB]),
        .i_cy    (r_shadow[POS_Y_MSB:POS_Y_LSB]),
        .o_hit   (is_ball),
        .o_valid (is_ball_valid)
    );

endmodule

// File: tb/tb_ball_sprite_render.sv
// Directed testbench for ball_sprite_render (RADIUS = 4, HIDE_X = 10'h3FF).
module tb_ball_sprite_render;

    logic        clk;
    logic        reset_n;
    logic [19:0] ball_pos_in;
    logic        frame_sync;
    logic        pix_valid;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic        is_ball;
    logic        is_ball_valid;
    logic        pos_updated;

    int n_cmp = 0;
    int n_err = 0;

    ball_sprite_render dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ball_pos_in   (ball_pos_in),
        .frame_sync    (frame_sync),
        .pix_valid     (pix_valid),
        .draw_x        (draw_x),
        .draw_y        (draw_y),
        .is_ball       (is_ball),
        .is_ball_valid (is_ball_valid),
        .pos_updated   (pos_updated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel for one cycle, then return the result two edges later.
    task automatic send_pixel(input logic [9:0] x, input logic [9:0] y,
                              output logic hit, output logic vld);
        draw_x    = x;
        draw_y    = y;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        tick();
        hit = is_ball;
        vld = is_ball_valid;
    endtask

    // Pulse frame_sync with a position; returns pos_updated one cycle later.
    task automatic do_sync(input logic [9:0] x, input logic [9:0] y, output logic upd);
        ball_pos_in = {x, y};
        frame_sync  = 1'b1;
        tick();
        frame_sync  = 1'b0;
        upd = pos_updated;
    endtask

    task automatic test_reset();
        logic [9:0] pat;
        logic       prev;
        reset_n     = 1'b0;
        ball_pos_in = '0;
        frame_sync  = 1'b0;
        pix_valid   = 1'b0;
        draw_x      = '0;
        draw_y      = '0;
        tick();
        tick();
        n_cmp++;
        if ({is_ball, is_ball_valid, pos_updated} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 000", {is_ball, is_ball_valid, pos_updated});
        end
        reset_n = 1'b1;
        tick();
        // Stream at the (reset) centre with no sync: valid must follow, no hit.
        pat  = 10'b0001101101;
        prev = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pix_valid = pat[i];
            draw_x    = 10'd0;
            draw_y    = 10'd0;
            tick();
            if (i >= 1) begin
                n_cmp++;
                if (is_ball_valid !== prev) begin
                    n_err++;
                    $display("FAIL nosync_valid[%0d]: got %b want %b", i, is_ball_valid, prev);
                end
                n_cmp++;
                if (is_ball !== 1'b0) begin
                    n_err++;
                    $display("FAIL nosync_hit[%0d]: got %b want 0", i, is_ball);
                end
            end
            prev = pat[i];
        end
        pix_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_basic();
        logic upd, hit, vld;
        do_sync(10'd100, 10'd50, upd);
        n_cmp++;
        if (upd !== 1'b1) begin
            n_err++;
            $display("FAIL basic_pos_updated: got %b want 1", upd);
        end
        tick();
        n_cmp++;
        if (pos_updated !== 1'b0) begin
            n_err++;
            $display("FAIL basic_pos_updated_pulse: got %b want 0", pos_updated);
        end
        send_pixel(10'd100, 10'd50, hit, vld);
        n_cmp++;
        if ({hit, vld} !== 2'b11) begin
            n_err++;
            $display("FAIL basic_centre_hit: got %b want 11", {hit, vld});
        end
    endtask

    task automatic test_radius();
        logic [9:0] xs [6] = '{10'd104, 10'd105, 10'd103, 10'd102, 10'd96, 10'd100};
        logic [9:0] ys [6] = '{10'd50,  10'd50,  10'd53,  10'd53,  10'd50, 10'd45};
        logic       exp[6] = '{1'b1,    1'b0,    1'b0,    1'b1,    1'b1,   1'b0};
        logic hit, vld;
        for (int i = 0; i < 6; i++) begin
            send_pixel(xs[i], ys[i], hit, vld);
            n_cmp++;
            if (hit !== exp[i] || vld !== 1'b1) begin
                n_err++;
                $display("FAIL radius(%0d,%0d): got hit=%b vld=%b want hit=%b vld=1",
                         xs[i], ys[i], hit, vld, exp[i]);
            end
        end
    endtask

    task automatic test_no_tear();
        logic upd, hit, vld;
        ball_pos_in = {10'd200, 10'd50};
        tick();
        send_pixel(10'd100, 10'd50, hit, vld);
        n_cmp++;
        if (hit !== 1'b1) begin
            n_err++;
            $display("FAIL notear_old_pos: got %b want 1", hit);
        end
        do_sync(10'd200, 10'd50, upd);
        n_cmp++;
        if (upd !== 1'b1) begin
            n_err++;
            $display("FAIL notear_pos_updated: got %b want 1", upd);
        end
        send_pixel(10'd200, 10'd50, hit, vld);
        n_cmp++;
        if (hit !== 1'b1) begin
            n_err++;
            $display("FAIL notear_new_pos: got %b want 1", hit);
        end
        send_pixel(10'd100, 10'd50, hit, vld);
        n_cmp++;
        if (hit !== 1'b0) begin
            n_err++;
            $display("FAIL notear_old_gone: got %b want 0", hit);
        end
        do_sync(10'd200, 10'd50, upd);
        n_cmp++;
        if (upd !== 1'b0) begin
            n_err++;
            $display("FAIL notear_unchanged_sync: got %b want 0", upd);
        end
    endtask

    task automatic test_hidden();
        logic upd, hit, vld;
        do_sync(10'h3FF, 10'd10, upd);
        n_cmp++;
        if (upd !== 1'b1) begin
            n_err++;
            $display("FAIL hidden_pos_updated: got %b want 1", upd);
        end
        for (int x = 1020; x < 1024; x++) begin
            send_pixel(10'(x), 10'd10, hit, vld);
            n_cmp++;
            if (hit !== 1'b0 || vld !== 1'b1) begin
                n_err++;
                $display("FAIL hidden(%0d,10): got hit=%b vld=%b want hit=0 vld=1", x, hit, vld);
            end
        end
    endtask

    // Sync and pixel in the same cycle: the pixel still sees the old (hidden) shadow.
    task automatic test_coincident();
        logic hit, vld;
        ball_pos_in = {10'd300, 10'd300};
        frame_sync  = 1'b1;
        pix_valid   = 1'b1;
        draw_x      = 10'd300;
        draw_y      = 10'd300;
        tick();
        frame_sync  = 1'b0;
        pix_valid   = 1'b0;
        tick();
        n_cmp++;
        if ({is_ball, is_ball_valid} !== 2'b01) begin
            n_err++;
            $display("FAIL coincident_old_shadow: got %b want 01", {is_ball, is_ball_valid});
        end
        send_pixel(10'd300, 10'd300, hit, vld);
        n_cmp++;
        if (hit !== 1'b1) begin
            n_err++;
            $display("FAIL coincident_new_shadow: got %b want 1", hit);
        end
    endtask

    task automatic test_edge_and_reset();
        logic upd, hit, vld;
        do_sync(10'd0, 10'd0, upd);
        send_pixel(10'd0, 10'd3, hit, vld);
        n_cmp++;
        if (hit !== 1'b1) begin
            n_err++;
            $display("FAIL edge(0,3): got %b want 1", hit);
        end
        send_pixel(10'd1023, 10'd0, hit, vld);
        n_cmp++;
        if (hit !== 1'b0) begin
            n_err++;
            $display("FAIL edge(1023,0): got %b want 0", hit);
        end
        send_pixel(10'd3, 10'd2, hit, vld);
        n_cmp++;
        if (hit !== 1'b1) begin
            n_err++;
            $display("FAIL edge(3,2): got %b want 1", hit);
        end
        send_pixel(10'd1, 10'd4, hit, vld);
        n_cmp++;
        if (hit !== 1'b0) begin
            n_err++;
            $display("FAIL edge(1,4): got %b want 0", hit);
        end
        // Mid-stream reset while a hit is on the outputs.
        draw_x    = 10'd0;
        draw_y    = 10'd0;
        pix_valid = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({is_ball, is_ball_valid} !== 2'b11) begin
            n_err++;
            $display("FAIL prereset_hit: got %b want 11", {is_ball, is_ball_valid});
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({is_ball, is_ball_valid, pos_updated} !== 3'b000) begin
            n_err++;
            $display("FAIL async_reset: got %b want 000", {is_ball, is_ball_valid, pos_updated});
        end
        pix_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        send_pixel(10'd0, 10'd0, hit, vld);
        n_cmp++;
        if ({hit, vld} !== 2'b01) begin
            n_err++;
            $display("FAIL postreset_hidden: got %b want 01", {hit, vld});
        end
        do_sync(10'd0, 10'd0, upd);
        n_cmp++;
        if (upd !== 1'b1) begin
            n_err++;
            $display("FAIL postreset_first_load: got %b want 1", upd);
        end
        send_pixel(10'd0, 10'd0, hit, vld);
        n_cmp++;
        if (hit !== 1'b1) begin
            n_err++;
            $display("FAIL postreset_hit: got %b want 1", hit);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_radius();
        test_no_tear();
        test_hidden();
        test_coincident();
        test_edge_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
